// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch resolver with registered redirect and flush window
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic             eq_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] offset_in,
  output logic             redirect,
  output logic [WIDTH-1:0] target_pc,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] BR_BEQ = 2'b00;
  localparam logic [1:0] BR_BNE = 2'b01;
  localparam logic [1:0] BR_JMP = 2'b10;
  localparam logic [1:0] BR_RSV = 2'b11;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_redirect;
  logic             r_flush;
  logic             r_busy;
  logic [WIDTH-1:0] r_target;

  logic             w_accept;
  logic             w_cond;
  logic             w_taken;
  logic [WIDTH-1:0] w_target;

  assign w_accept = br_valid && (r_state == ST_IDLE) && (br_type != BR_RSV);
  assign w_cond   = ((br_type == BR_BEQ) && eq_in) ||
                    ((br_type == BR_BNE) && !eq_in) ||
                    (br_type == BR_JMP);
  assign w_taken  = w_accept && w_cond;
  // Word offset scaled to bytes; overflow wraps silently.
  assign w_target = pc_in + (offset_in << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_redirect <= 1'b0;
      r_flush    <= 1'b0;
      r_busy     <= 1'b0;
      r_target   <= '0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_taken) begin
            r_target   <= w_target;
            r_redirect <= 1'b1;
            r_flush    <= 1'b1;
            r_busy     <= 1'b1;
            r_cnt      <= FLUSH_LOAD;
            r_state    <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (r_cnt == 4'd0) begin
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_flush <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign redirect  = r_redirect;
  assign target_pc = r_target;
  assign flush     = r_flush;
  assign busy      = r_busy;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  // Counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      if (w_accept && (r_branch_cnt != {CNT_W{1'b1}}))
        r_branch_cnt <= r_branch_cnt + 1'b1;
      if (w_taken && (r_taken_cnt != {CNT_W{1'b1}}))
        r_taken_cnt <= r_taken_cnt + 1'b1;
    end
  end

  assign branch_cnt = r_branch_cnt;
  assign taken_cnt  = r_taken_cnt;
`else
  assign branch_cnt = '0;
  assign taken_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - randomized and directed bench for branch_resolve_unit
module tb_branch_resolve_unit;
  localparam int W  = 32;
  localparam int FC = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          br_valid;
  logic [1:0]    br_type;
  logic          eq_in;
  logic [W-1:0]  pc_in;
  logic [W-1:0]  offset_in;
  logic          redirect;
  logic [W-1:0]  target_pc;
  logic          flush;
  logic          busy;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] taken_cnt;

  branch_resolve_unit #(.WIDTH(W), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_type(br_type), .eq_in(eq_in),
    .pc_in(pc_in), .offset_in(offset_in), .redirect(redirect), .target_pc(target_pc),
    .flush(flush), .busy(busy), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining window length, last target, stats totals.
  int           m_win;
  logic [W-1:0] m_target;
  logic         m_redirect;
  int           m_br;
  int           m_tk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < (1 << CW) - 1) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_win = 0; m_target = '0; m_redirect = 1'b0; m_br = 0; m_tk = 0;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] t, input logic e,
                            input logic [W-1:0] pc, input logic [W-1:0] off);
    logic tk;
    m_redirect = 1'b0;
    if (m_win > 0) begin
      m_win--;
    end else if (v && t != 2'b11) begin
      m_br = sat_inc(m_br);
      tk = (t == 2'b00 && e) || (t == 2'b01 && !e) || (t == 2'b10);
      if (tk) begin
        m_tk       = sat_inc(m_tk);
        m_win      = FC;
        m_target   = pc + (off << 2);
        m_redirect = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    int exp_br, exp_tk;
`ifdef BRANCH_STATS_EN
    exp_br = m_br; exp_tk = m_tk;
`else
    exp_br = 0; exp_tk = 0;
`endif
    check({ctx, ".redirect"}, 64'(redirect), 64'(m_redirect));
    check({ctx, ".flush"}, 64'(flush), 64'(m_win > 0));
    check({ctx, ".busy"}, 64'(busy), 64'(m_win > 0));
    check({ctx, ".target"}, 64'(target_pc), 64'(m_target));
    check({ctx, ".branch_cnt"}, 64'(branch_cnt), 64'(exp_br));
    check({ctx, ".taken_cnt"}, 64'(taken_cnt), 64'(exp_tk));
  endtask

  task automatic step(input string ctx, input logic v, input logic [1:0] t, input logic e,
                      input logic [W-1:0] pc, input logic [W-1:0] off);
    br_valid = v; br_type = t; eq_in = e; pc_in = pc; offset_in = off;
    @(posedge clk);
    model_edge(v, t, e, pc, off);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 2'b00, 1'b0, '0, '0);
  endtask

  // Asserts reset between edges and checks outputs clear before any clock edge.
  task automatic do_reset(input string ctx);
    br_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(ctx);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; br_valid = 1'b0; br_type = 2'b00; eq_in = 1'b0; pc_in = '0; offset_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    step("beq_taken", 1'b1, 2'b00, 1'b1, 32'd100, 32'd4);
    check("beq_taken.target116", 64'(target_pc), 64'd116);
    check("beq_taken.redirect1", 64'(redirect), 64'd1);
    idle(2);
    check("beq_taken.flush_end", 64'(flush), 64'd0);

    step("beq_not_taken", 1'b1, 2'b00, 1'b0, 32'd190, 32'd50);
    check("beq_not_taken.hold", 64'(target_pc), 64'd116);

    step("bne_neg", 1'b1, 2'b01, 1'b0, 32'd64, 32'hFFFF_FFFC);
    check("bne_neg.target48", 64'(target_pc), 64'd48);
    step("jmp_in_flush0", 1'b1, 2'b10, 1'b0, 32'd200, 32'd8);
    step("jmp_in_flush1", 1'b1, 2'b10, 1'b0, 32'd200, 32'd8);
    step("jmp_after_busy", 1'b1, 2'b10, 1'b0, 32'd200, 32'd8);
    check("jmp_after_busy.target232", 64'(target_pc), 64'd232);
    check("jmp_after_busy.redirect1", 64'(redirect), 64'd1);
    idle(2);

    step("reserved", 1'b1, 2'b11, 1'b1, 32'd4, 32'd4);
    step("wrap", 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'd1);
    check("wrap.target0", 64'(target_pc), 64'd0);
    step("pre_abort", 1'b0, 2'b00, 1'b0, '0, '0);
    do_reset("abort");
    idle(3);

    for (int i = 0; i < 5; i++) begin
      step("sat_jmp", 1'b1, 2'b10, 1'b0, 32'(i * 16), 32'd1);
      idle(2);
    end
`ifdef BRANCH_STATS_EN
    check("sat.taken3", 64'(taken_cnt), 64'd3);
`else
    check("nostats.taken0", 64'(taken_cnt), 64'd0);
`endif

    do_reset("reset2");
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom(),
           ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed(8'($urandom()))));
      if ($urandom_range(0, 199) == 0) do_reset("rand_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
